// File: rtl/capture_ctrl.sv
// Capture sequencer: packs samples into LSB-first byte triplets for the FIFO,
// decodes SPI commands and serves status or FIFO data bytes to the SPI slave.
module capture_ctrl #(
  parameter int         DATA_SIZE    = 24,
  parameter int         SAMPLE_BYTES = 3,
  parameter int         DEPTH        = 131072,
  parameter int         LEVEL_WIDTH  = 18,
  parameter logic [7:0] FILL_BYTE    = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [DATA_SIZE-1:0]   sample_data,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_wr_data,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   fifo_flush,
  input  logic                   spi_cs_n,
  input  logic                   spi_rx_valid,
  input  logic [7:0]             spi_rx_data,
  input  logic                   spi_tx_req,
  output logic [7:0]             spi_tx_data,
  output logic                   spi_tx_valid,
  output logic                   capturing,
  output logic [7:0]             overrun_count,
  output logic [1:0]             wr_state_dbg,
  output logic                   cmd_state_dbg
);

  // Handshakes: sample_valid, spi_rx_valid and spi_tx_req are single-cycle
  // pulses with no backpressure; spi_tx_valid pulses once per spi_tx_req.
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_B1 = 2'd1, W_B2 = 2'd2} wr_state_t;
  typedef enum logic {C_CMD = 1'b0, C_DATA = 1'b1} cmd_state_t;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_FLUSH = 8'h04;
  localparam logic [7:0] CMD_READ  = 8'h05;
  localparam logic [LEVEL_WIDTH-1:0] ROOM_LIMIT = LEVEL_WIDTH'(DEPTH - SAMPLE_BYTES);

  wr_state_t  wr_state, wr_state_nxt;
  cmd_state_t cmd_state, cmd_state_nxt;

  logic [DATA_SIZE-1:8] sample_q;
  logic                 load_sample;
  logic                 wr_en_nxt;
  logic [7:0]           wr_data_nxt;
  logic                 capturing_nxt;
  logic                 rd_en_nxt;
  logic                 rd_pending;
  logic                 tx_valid_q, tx_valid_nxt;
  logic [7:0]           tx_data_q, tx_data_nxt;
  logic                 cs_n_q;

  logic flush_cmd, has_room, sample_seen, accept, overrun;

  assign flush_cmd   = spi_rx_valid && (cmd_state == C_CMD) && (spi_rx_data == CMD_FLUSH);
  assign has_room    = (fifo_level <= ROOM_LIMIT);
  // A flush in the same cycle swallows the sample without counting it.
  assign sample_seen = sample_valid && capturing && !flush_cmd;
  assign accept      = sample_seen && (wr_state == W_IDLE) && has_room;
  assign overrun     = sample_seen && !accept;

  always_comb begin
    wr_state_nxt = wr_state;
    wr_en_nxt    = 1'b0;
    wr_data_nxt  = 8'h00;
    load_sample  = 1'b0;
    if (flush_cmd) begin
      wr_state_nxt = W_IDLE;
    end else begin
      case (wr_state)
        W_IDLE: if (accept) begin
          wr_en_nxt    = 1'b1;
          wr_data_nxt  = sample_data[7:0];
          load_sample  = 1'b1;
          wr_state_nxt = W_B1;
        end
        W_B1: begin
          wr_en_nxt    = 1'b1;
          wr_data_nxt  = sample_q[15:8];
          wr_state_nxt = W_B2;
        end
        W_B2: begin
          wr_en_nxt    = 1'b1;
          wr_data_nxt  = sample_q[23:16];
          wr_state_nxt = W_IDLE;
        end
        default: wr_state_nxt = W_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_state_nxt = cmd_state;
    capturing_nxt = capturing;
    rd_en_nxt     = 1'b0;
    tx_valid_nxt  = 1'b0;
    tx_data_nxt   = tx_data_q;
    case (cmd_state)
      C_CMD: if (spi_rx_valid) begin
        case (spi_rx_data)
          CMD_START: capturing_nxt = 1'b1;
          CMD_STOP:  capturing_nxt = 1'b0;
          CMD_READ:  cmd_state_nxt = C_DATA;
          default:   cmd_state_nxt = C_CMD;
        endcase
      end
      C_DATA: if (spi_cs_n && !cs_n_q) cmd_state_nxt = C_CMD;
      default: cmd_state_nxt = C_CMD;
    endcase
    // Data bytes come back through the FIFO read port one cycle later;
    // status and fill bytes are answered directly.
    if (spi_tx_req) begin
      if ((cmd_state == C_DATA) && !fifo_empty) begin
        rd_en_nxt = 1'b1;
      end else begin
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = (cmd_state == C_DATA) ? FILL_BYTE
                     : {capturing, (overrun_count != 8'h00), fifo_full, fifo_empty, 4'b0000};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state      <= W_IDLE;
      cmd_state     <= C_CMD;
      sample_q      <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= 8'h00;
      fifo_rd_en    <= 1'b0;
      fifo_flush    <= 1'b0;
      rd_pending    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      capturing     <= 1'b0;
      overrun_count <= 8'h00;
      cs_n_q        <= 1'b1;
    end else begin
      wr_state     <= wr_state_nxt;
      cmd_state    <= cmd_state_nxt;
      fifo_wr_en   <= wr_en_nxt;
      fifo_wr_data <= wr_data_nxt;
      if (load_sample) sample_q <= sample_data[DATA_SIZE-1:8];
      fifo_rd_en   <= rd_en_nxt;
      fifo_flush   <= flush_cmd;
      rd_pending   <= fifo_rd_en;
      tx_valid_q   <= tx_valid_nxt;
      tx_data_q    <= tx_data_nxt;
      capturing    <= capturing_nxt;
      cs_n_q       <= spi_cs_n;
      if (flush_cmd)
        overrun_count <= 8'h00;
      else if (overrun && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'h01;
    end
  end

  assign spi_tx_valid  = tx_valid_q | rd_pending;
  assign spi_tx_data   = rd_pending ? fifo_rd_data : tx_data_q;
  assign wr_state_dbg  = wr_state;
  assign cmd_state_dbg = cmd_state;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural byte FIFO and output monitors.
module tb_capture_ctrl;
  localparam int DATA_SIZE   = 24;
  localparam int DEPTH       = 131072;
  localparam int LEVEL_WIDTH = 18;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sample_valid;
  logic [DATA_SIZE-1:0]   sample_data;
  logic                   fifo_wr_en;
  logic [7:0]             fifo_wr_data;
  logic                   fifo_rd_en;
  logic [7:0]             fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LEVEL_WIDTH-1:0] fifo_level;
  logic                   fifo_flush;
  logic                   spi_cs_n;
  logic                   spi_rx_valid;
  logic [7:0]             spi_rx_data;
  logic                   spi_tx_req;
  logic [7:0]             spi_tx_data;
  logic                   spi_tx_valid;
  logic                   capturing;
  logic [7:0]             overrun_count;
  logic [1:0]             wr_state_dbg;
  logic                   cmd_state_dbg;

  always #5 clk = ~clk;

  capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .fifo_flush(fifo_flush), .spi_cs_n(spi_cs_n),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_tx_req(spi_tx_req),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .capturing(capturing),
    .overrun_count(overrun_count), .wr_state_dbg(wr_state_dbg), .cmd_state_dbg(cmd_state_dbg)
  );

  // Behavioural FIFO: read data appears the cycle after fifo_rd_en.
  logic [7:0] fifo_q[$];
  int         fifo_cnt = 0;
  logic       pre_wr_en = 1'b0;
  logic [7:0] pre_wr_data = 8'h00;
  logic       force_lvl = 1'b0;
  logic [LEVEL_WIDTH-1:0] force_val = '0;

  initial fifo_rd_data = 8'h00;

  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (fifo_wr_en) fifo_q.push_back(fifo_wr_data);
      if (pre_wr_en) fifo_q.push_back(pre_wr_data);
    end
    fifo_cnt <= fifo_q.size();
  end

  assign fifo_level = force_lvl ? force_val : LEVEL_WIDTH'(fifo_cnt);
  assign fifo_full  = (fifo_level == LEVEL_WIDTH'(DEPTH));
  assign fifo_empty = (fifo_cnt == 0);

  // Cycle stamp and output monitors, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         rd_cnt = 0;
  int         flush_cnt = 0;

  always @(negedge clk) begin
    if (fifo_wr_en) begin wr_log.push_back(fifo_wr_data); wr_cyc.push_back(cyc); end
    if (spi_tx_valid) begin tx_log.push_back(spi_tx_data); tx_cyc.push_back(cyc); end
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_flush) flush_cnt <= flush_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk); spi_rx_valid = 1'b1; spi_rx_data = b;
    @(negedge clk); spi_rx_valid = 1'b0;
  endtask

  task automatic pulse_sample(input logic [23:0] d, output int c0);
    @(negedge clk); sample_valid = 1'b1; sample_data = d; c0 = cyc;
    @(negedge clk); sample_valid = 1'b0;
  endtask

  task automatic tx_request(output int c0);
    @(negedge clk); spi_tx_req = 1'b1; c0 = cyc;
    @(negedge clk); spi_tx_req = 1'b0;
  endtask

  task automatic preload(input logic [7:0] b);
    @(negedge clk); pre_wr_en = 1'b1; pre_wr_data = b;
    @(negedge clk); pre_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; spi_cs_n = 1'b0;
    spi_rx_valid = 1'b0; spi_rx_data = 8'h00; spi_tx_req = 1'b0;
    tick(3);
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_checks++; if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++; if (fifo_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", fifo_flush); end
    n_checks++; if (spi_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", spi_tx_valid); end
    n_checks++; if (spi_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", spi_tx_data); end
    n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL reset_capturing: got %b want 0", capturing); end
    n_checks++; if (overrun_count !== 8'h00) begin n_fail++; $display("FAIL reset_overrun: got %h want 00", overrun_count); end
    n_checks++; if ({wr_state_dbg, cmd_state_dbg} !== 3'b000) begin n_fail++; $display("FAIL reset_states: got %b want 000", {wr_state_dbg, cmd_state_dbg}); end
    rst_n = 1'b1;
    tick(1);
  endtask

  // Checks bytes and back-to-back timing of a triplet started by a sample driven at cycle c0.
  task automatic check_triplet(input string name, input int base, input int c0, input logic [23:0] d);
    exp_q = {d[7:0], d[15:8], d[23:16]};
    n_checks++;
    if (wr_log.size() - base !== 3) begin
      n_fail++; $display("FAIL %s_count: got %0d writes want 3", name, wr_log.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_log[base+i] !== exp_q[i] || wr_cyc[base+i] !== c0 + 1 + i) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %h at cycle %0d want %h at cycle %0d",
                   name, i, wr_log[base+i], wr_cyc[base+i], exp_q[i], c0 + 1 + i);
        end
      end
    end
  endtask

  task automatic check_tx(input string name, input int idx, input int c0, input logic [7:0] b, input int lat);
    n_checks++;
    if (tx_log.size() <= idx) begin
      n_fail++; $display("FAIL %s: no tx byte seen, want %h", name, b);
    end else if (tx_log[idx] !== b || tx_cyc[idx] - c0 !== lat) begin
      n_fail++; $display("FAIL %s: got %h latency %0d want %h latency %0d", name, tx_log[idx], tx_cyc[idx] - c0, b, lat);
    end
  endtask

  task automatic test_capture;
    int base, c0;
    send_cmd(8'h01);
    n_checks++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL start_capturing: got %b want 1", capturing); end
    base = wr_log.size();
    pulse_sample(24'hFF66AA, c0);
    tick(4);
    check_triplet("capture", base, c0, 24'hFF66AA);
  endtask

  task automatic test_overrun;
    int base, c0, tb;
    force_val = LEVEL_WIDTH'(DEPTH - 2); force_lvl = 1'b1;
    base = wr_log.size();
    pulse_sample(24'h123456, c0);
    tick(3);
    n_checks++; if (wr_log.size() !== base) begin n_fail++; $display("FAIL overrun_nowrite: got %0d writes want 0", wr_log.size() - base); end
    n_checks++; if (overrun_count !== 8'd1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", overrun_count); end
    tb = tx_log.size();
    tx_request(c0);
    tick(2);
    check_tx("status_overrun", tb, c0, 8'b1100_0000, 1);
    force_val = LEVEL_WIDTH'(DEPTH - 3);
    base = wr_log.size();
    pulse_sample(24'hABCDEF, c0);
    tick(4);
    check_triplet("room_boundary", base, c0, 24'hABCDEF);
    force_lvl = 1'b0;
  endtask

  task automatic test_back_to_back;
    int base, c0;
    base = wr_log.size();
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'h010203; c0 = cyc;
    @(negedge clk); sample_data = 24'h040506;
    @(negedge clk); sample_valid = 1'b0;
    tick(4);
    check_triplet("b2b", base, c0, 24'h010203);
    n_checks++; if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 2", overrun_count); end
  endtask

  task automatic test_flush;
    int base, c0, fb, tb;
    force_val = LEVEL_WIDTH'(DEPTH); force_lvl = 1'b1;
    base = wr_log.size();
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'h555555;
    repeat (300) @(negedge clk);
    sample_valid = 1'b0;
    tick(2);
    n_checks++; if (overrun_count !== 8'd255) begin n_fail++; $display("FAIL saturate: got %0d want 255", overrun_count); end
    n_checks++; if (wr_log.size() !== base) begin n_fail++; $display("FAIL full_nowrite: got %0d writes want 0", wr_log.size() - base); end
    tb = tx_log.size();
    tx_request(c0);
    tick(2);
    check_tx("status_full", tb, c0, 8'b1110_0000, 1);
    force_lvl = 1'b0;

    base = wr_log.size(); fb = flush_cnt;
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'h778899;
    @(negedge clk); sample_valid = 1'b0; spi_rx_valid = 1'b1; spi_rx_data = 8'h04;
    @(negedge clk); spi_rx_valid = 1'b0;
    tick(4);
    n_checks++; if (flush_cnt - fb !== 1) begin n_fail++; $display("FAIL flush_pulse: got %0d pulses want 1", flush_cnt - fb); end
    n_checks++; if (overrun_count !== 8'h00) begin n_fail++; $display("FAIL flush_overrun: got %0d want 0", overrun_count); end
    for (int i = base; i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] === 8'h77) begin n_fail++; $display("FAIL flush_abandon: got byte 77 written want none"); end
    end
    n_checks++; if (wr_log.size() - base < 1 || wr_log[base] !== 8'h99) begin n_fail++; $display("FAIL flush_first_byte: got %0d writes want first byte 99", wr_log.size() - base); end

    base = wr_log.size(); fb = flush_cnt;
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'hC0FFEE; spi_rx_valid = 1'b1; spi_rx_data = 8'h04;
    @(negedge clk); sample_valid = 1'b0; spi_rx_valid = 1'b0;
    tick(4);
    n_checks++; if (wr_log.size() !== base) begin n_fail++; $display("FAIL flush_priority: got %0d writes want 0", wr_log.size() - base); end
    n_checks++; if (flush_cnt - fb !== 1 || overrun_count !== 8'h00) begin n_fail++; $display("FAIL flush_priority_state: got %0d pulses overrun %0d want 1 and 0", flush_cnt - fb, overrun_count); end

    base = wr_log.size();
    pulse_sample(24'h112233, c0);
    tick(4);
    check_triplet("post_flush", base, c0, 24'h112233);
  endtask

  task automatic test_stop;
    int base, c0;
    base = wr_log.size();
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'h445566; c0 = cyc;
    @(negedge clk); sample_valid = 1'b0; spi_rx_valid = 1'b1; spi_rx_data = 8'h02;
    @(negedge clk); spi_rx_valid = 1'b0;
    tick(3);
    check_triplet("stop_complete", base, c0, 24'h445566);
    n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL stop_capturing: got %b want 0", capturing); end
    base = wr_log.size();
    pulse_sample(24'hDEAD00, c0);
    tick(3);
    n_checks++; if (wr_log.size() !== base || overrun_count !== 8'h00) begin n_fail++; $display("FAIL stopped_sample: got %0d writes overrun %0d want 0 and 0", wr_log.size() - base, overrun_count); end
  endtask

  task automatic test_read;
    int tb, rb;
    int c[4];
    logic [7:0] exp_b[4];
    int exp_l[4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h00};
    exp_l = '{2, 2, 2, 1};
    send_cmd(8'h04);
    tick(2);
    preload(8'h11); preload(8'h22); preload(8'h33);
    send_cmd(8'h05);
    tb = tx_log.size(); rb = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      tx_request(c[i]);
      tick(4);
    end
    n_checks++; if (tx_log.size() - tb !== 4) begin n_fail++; $display("FAIL read_count: got %0d tx bytes want 4", tx_log.size() - tb); end
    for (int i = 0; i < 4; i++) check_tx("read_byte", tb + i, c[i], exp_b[i], exp_l[i]);
    n_checks++; if (rd_cnt - rb !== 3) begin n_fail++; $display("FAIL read_rd_en: got %0d pulses want 3", rd_cnt - rb); end
  endtask

  task automatic test_leave_data;
    int tb, c0;
    send_cmd(8'h01);
    n_checks++; if (capturing !== 1'b0 || cmd_state_dbg !== 1'b1) begin n_fail++; $display("FAIL data_ignore_cmd: got capturing %b state %b want 0 and 1", capturing, cmd_state_dbg); end
    @(negedge clk); spi_cs_n = 1'b1;
    tick(2); spi_cs_n = 1'b0;
    tick(1);
    n_checks++; if (cmd_state_dbg !== 1'b0) begin n_fail++; $display("FAIL cs_exit: got state %b want 0", cmd_state_dbg); end
    tb = tx_log.size();
    tx_request(c0);
    tick(2);
    check_tx("status_after_exit", tb, c0, 8'b0001_0000, 1);

    send_cmd(8'h05);
    preload(8'h5A);
    tb = tx_log.size();
    tx_request(c0);
    spi_cs_n = 1'b1;
    tick(3); spi_cs_n = 1'b0;
    tick(1);
    check_tx("inflight_read", tb, c0, 8'h5A, 2);
    send_cmd(8'h01);
    n_checks++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL cmd_after_exit: got capturing %b want 1", capturing); end
  endtask

  task automatic test_reset_mid;
    int base;
    base = wr_log.size();
    @(negedge clk); sample_valid = 1'b1; sample_data = 24'h0F0E0D;
    @(negedge clk); sample_data = 24'h999999;
    @(negedge clk); sample_valid = 1'b0;
    n_checks++; if (overrun_count !== 8'd1) begin n_fail++; $display("FAIL mid_overrun: got %0d want 1", overrun_count); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_wr_en !== 1'b0 || capturing !== 1'b0 || overrun_count !== 8'h00 || wr_state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset: got wr_en %b cap %b ovr %0d state %0d want all 0", fifo_wr_en, capturing, overrun_count, wr_state_dbg);
    end
    rst_n = 1'b1;
    tick(4);
    n_checks++; if (wr_log.size() - base !== 2) begin n_fail++; $display("FAIL mid_discard: got %0d writes want 2", wr_log.size() - base); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overrun();
    test_back_to_back();
    test_flush();
    test_stop();
    test_read();
    test_leave_data();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
